// File: rtl/edge_row_packer_pkg.sv
// Shared constants and row-entry layout for the edge row packer.
// The packed struct below matches the default configuration (18-bit rows, 11-bit tile counter).
package edge_pkg;

  localparam int TILE_EDGE      = 18;
  localparam int TILE_BITS      = TILE_EDGE * TILE_EDGE;
  localparam int ROW_IDX_W      = 5;
  localparam int TILE_CNT_W_DEF = 11;

  typedef struct packed {
    logic [TILE_CNT_W_DEF-1:0] tile;
    logic [ROW_IDX_W-1:0]      row;
    logic                      last;
    logic [TILE_EDGE-1:0]      data;
  } row_entry_t;

endpackage

// File: rtl/edge_row_packer_if.sv
// Row output channel: FIFO head fields plus valid/ready handshake.
interface edge_row_packer_if #(
  parameter int ROW_W      = 18,
  parameter int TILE_CNT_W = 11
);
  import edge_pkg::*;

  logic [ROW_W-1:0]      row_data;
  logic [ROW_IDX_W-1:0]  row_idx;
  logic                  row_last;
  logic [TILE_CNT_W-1:0] tile_idx;
  logic                  row_valid;
  logic                  row_ready;

  modport master (
    output row_data, row_idx, row_last, tile_idx, row_valid,
    input  row_ready
  );

  modport slave (
    input  row_data, row_idx, row_last, tile_idx, row_valid,
    output row_ready
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/edge_row_packer.sv
// Packs the serial edge bit stream into rows tagged with row/tile indices and
// buffers them in a FIFO; rows lost to a full FIFO set a sticky overflow flag.
module edge_row_packer
  import edge_pkg::*;
#(
  parameter int ROW_W      = TILE_EDGE,
  parameter int FIFO_DEPTH = 4,
  parameter int TILE_CNT_W = TILE_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                edge_in,
  input  logic                edge_valid,
  edge_row_packer_if.master   row_if,
  output logic                tile_done,
  output logic                overflow
);

  typedef struct packed {
    logic [TILE_CNT_W-1:0] tile;
    logic [ROW_IDX_W-1:0]  row;
    logic                  last;
    logic [ROW_W-1:0]      data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam logic [ROW_IDX_W-1:0] LAST_IDX = ROW_IDX_W'(ROW_W - 1);

  logic [ROW_IDX_W-1:0]  col_cnt_q, col_cnt_d;
  logic [ROW_IDX_W-1:0]  row_cnt_q, row_cnt_d;
  logic [TILE_CNT_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [ROW_W-1:0]      shreg_q, shreg_d;
  logic                  tile_done_q, tile_done_d;
  logic                  overflow_q, overflow_d;

  logic                  row_push;
  entry_t                push_entry;
  entry_t                head;
  logic [ENTRY_W-1:0]    head_bits;
  logic                  fifo_full, fifo_empty;

  // The pushed row uses shreg_d so it already contains the bit arriving this cycle.
  always_comb begin
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    tile_cnt_d  = tile_cnt_q;
    shreg_d     = shreg_q;
    tile_done_d = 1'b0;
    overflow_d  = overflow_q;
    row_push    = 1'b0;
    if (edge_valid) begin
      shreg_d[col_cnt_q] = edge_in;
      if (col_cnt_q == LAST_IDX) begin
        row_push  = 1'b1;
        col_cnt_d = '0;
        if (row_cnt_q == LAST_IDX) begin
          row_cnt_d   = '0;
          tile_cnt_d  = tile_cnt_q + TILE_CNT_W'(1);
          tile_done_d = 1'b1;
        end else begin
          row_cnt_d = row_cnt_q + ROW_IDX_W'(1);
        end
      end else begin
        col_cnt_d = col_cnt_q + ROW_IDX_W'(1);
      end
    end
    // A full FIFO always has a head, so row_ready alone decides whether a slot frees up.
    if (row_push && fifo_full && !row_if.row_ready) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    push_entry.tile = tile_cnt_q;
    push_entry.row  = row_cnt_q;
    push_entry.last = (row_cnt_q == LAST_IDX);
    push_entry.data = shreg_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      tile_cnt_q  <= '0;
      shreg_q     <= '0;
      tile_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
      shreg_q     <= shreg_d;
      tile_done_q <= tile_done_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (row_push),
    .push_data (push_entry),
    .pop       (row_if.row_ready),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head             = head_bits;
  assign row_if.row_data  = head.data;
  assign row_if.row_idx   = head.row;
  assign row_if.row_last  = head.last;
  assign row_if.tile_idx  = head.tile;
  assign row_if.row_valid = !fifo_empty;
  assign tile_done        = tile_done_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_edge_row_packer.sv
// Randomised scoreboard bench for edge_row_packer: a queue-based reference model
// predicts the FIFO contents, tile_done and overflow; a monitor compares every cycle.
module tb_edge_row_packer;
  import edge_pkg::*;

  localparam int ROW_W = 18;
  localparam int DEPTH = 4;
  // Narrow tile counter so the wrap is reached after a handful of tiles.
  localparam int TCW   = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic edge_in = 1'b0;
  logic edge_valid = 1'b0;
  logic tile_done;
  logic overflow;

  int n_checks = 0;
  int n_fails  = 0;
  logic mon_en = 1'b0;

  row_entry_t       exp_q[$];
  logic [ROW_W-1:0] cur_bits = '0;
  int               cur_col = 0;
  int               rows_done = 0;
  logic             exp_tile_done = 1'b0;
  logic             exp_overflow = 1'b0;

  edge_row_packer_if #(.ROW_W(ROW_W), .TILE_CNT_W(TCW)) row_if();

  edge_row_packer #(
    .ROW_W      (ROW_W),
    .FIFO_DEPTH (DEPTH),
    .TILE_CNT_W (TCW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .edge_in    (edge_in),
    .edge_valid (edge_valid),
    .row_if     (row_if),
    .tile_done  (tile_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check("rst_row_valid", row_if.row_valid, 0);
    check("rst_row_data", row_if.row_data, 0);
    check("rst_row_idx", row_if.row_idx, 0);
    check("rst_row_last", row_if.row_last, 0);
    check("rst_tile_idx", row_if.tile_idx, 0);
    check("rst_tile_done", tile_done, 0);
    check("rst_overflow", overflow, 0);
  endtask

  task automatic apply_stimulus(input logic v, input logic b, input logic rdy);
    @(posedge clk);
    #2;
    edge_valid = v;
    edge_in = b;
    row_if.row_ready = rdy;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    edge_valid = 1'b0;
    edge_in = 1'b0;
    row_if.row_ready = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    check_output();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, rdy);
  endtask

  // gap 0: back-to-back, 1: one idle cycle after every bit, 2: random gaps
  task automatic send_row(input logic [ROW_W-1:0] data, input logic rdy, input int gap);
    for (int i = 0; i < ROW_W; i++) begin
      apply_stimulus(1'b1, data[i], rdy);
      if (gap == 1) idle(1, rdy);
      else if (gap == 2) idle($urandom_range(0, 2), rdy);
    end
  endtask

  // Reference model: rows are numbered globally since reset; the expected
  // queue holds exactly what the FIFO should contain.
  initial begin
    row_entry_t e;
    int r;
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        cur_bits = '0;
        cur_col = 0;
        rows_done = 0;
        exp_tile_done = 1'b0;
        exp_overflow = 1'b0;
      end else begin
        exp_tile_done = 1'b0;
        if (edge_valid) begin
          cur_bits[cur_col] = edge_in;
          cur_col++;
          if (cur_col == ROW_W) begin
            r = rows_done % ROW_W;
            e.tile = TILE_CNT_W_DEF'((rows_done / ROW_W) % (1 << TCW));
            e.row  = ROW_IDX_W'(r);
            e.last = (r == ROW_W - 1);
            e.data = cur_bits;
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else exp_overflow = 1'b1;
            if (e.last) exp_tile_done = 1'b1;
            rows_done++;
            cur_col = 0;
          end
        end
      end
    end
  end

  // Monitor: compares the head every cycle and retires it when the sink takes it.
  initial begin
    row_entry_t h;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("tile_done", tile_done, exp_tile_done);
        check("overflow", overflow, exp_overflow);
        if (exp_q.size() > 0) begin
          h = exp_q[0];
          check("row_valid", row_if.row_valid, 1);
          check("row_data", row_if.row_data, h.data);
          check("row_idx", row_if.row_idx, h.row);
          check("row_last", row_if.row_last, h.last);
          check("tile_idx", row_if.tile_idx, h.tile);
          if (row_if.row_ready) void'(exp_q.pop_front());
        end else begin
          check("row_valid_idle", row_if.row_valid, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic rdy;
    row_if.row_ready = 1'b0;
    apply_reset();

    $display("[TB] single tile, sink always ready");
    for (int r = 0; r < ROW_W; r++) send_row(18'h2AAAA ^ 18'(r), 1'b1, 0);
    idle(5, 1'b1);

    $display("[TB] gapped input");
    apply_reset();
    for (int r = 0; r < 2; r++) send_row(18'h2AAAA ^ 18'(r), 1'b1, 1);
    idle(5, 1'b1);

    $display("[TB] backpressure and overflow");
    apply_reset();
    for (int r = 0; r < 5; r++) send_row(18'($urandom), 1'b0, 0);
    idle(6, 1'b0);
    idle(8, 1'b1);
    send_row(18'($urandom), 1'b1, 0);
    idle(5, 1'b1);

    $display("[TB] full FIFO with simultaneous push and pop");
    apply_reset();
    for (int b = 0; b < 5 * ROW_W; b++)
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), b == 5 * ROW_W - 1);
    idle(10, 1'b1);

    $display("[TB] mid-tile reset");
    apply_reset();
    for (int b = 0; b < 100; b++) apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    apply_reset();
    send_row(18'($urandom), 1'b1, 0);
    idle(5, 1'b1);

    $display("[TB] tile counter wrap");
    apply_reset();
    for (int t = 0; t < (1 << TCW) + 1; t++)
      for (int r = 0; r < ROW_W; r++) send_row('1, 1'b1, 0);
    idle(5, 1'b1);

    $display("[TB] random traffic");
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rdy = ((i / 150) % 4 == 3) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rdy);
    end

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/edge_row_packer.md
# edge_row_packer

Downstream companion to the Canny edge `CHIP`. It consumes the serial 1-bit `edge_out` stream that `CHIP` produces while `readable` is high: 18×18 = 324 bits per tile, raster order. It packs each 18-bit row into a word and buffers rows in a small FIFO. Rows leave on a valid/ready interface tagged with row and tile indices. `CHIP` cannot be stalled, so the FIFO absorbs sink backpressure, and any loss is flagged.

## Interface
Parameters:
- `ROW_W`, default 18: edge bits per row, and also rows per tile.
- `FIFO_DEPTH`, default 4: number of buffered row entries. Must be a power of 2, at least 2.
- `TILE_CNT_W`, default 11: tile counter width. Covers 1350 tiles; wraps modulo 2^11.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high. This is the packer's own reset. It is not tied to the per-tile `CHIP` reset.
- `edge_in`, in, 1: edge bit, driven from `CHIP.edge_out`.
- `edge_valid`, in, 1: driven from `CHIP.readable`. `edge_in` is sampled only when this is 1.
- `row_data`, out, `ROW_W`: packed row. Bit 0 is column 0, i.e. the first bit received.
- `row_idx`, out, 5: row number within the tile, 0..17.
- `row_last`, out, 1: set when `row_idx == ROW_W-1`.
- `tile_idx`, out, `TILE_CNT_W`: tile number of the presented row.
- `row_valid`, out, 1: FIFO head is valid.
- `row_ready`, in, 1: sink accepts the head.
- `tile_done`, out, 1: one-cycle pulse, the cycle after the 324th bit of a tile is sampled.
- `overflow`, out, 1: sticky. Set when a completed row is dropped.

## Operation
- **Shift register.** `shreg[col_cnt] <= edge_in` on each sampled bit.
- **Counters.**
  - `col_cnt` runs 0..17.
  - On the 18th bit: `col_cnt` returns to 0, `row_cnt` increments.
  - On row 17, column 17: `row_cnt` returns to 0, `tile_cnt` increments (wrapping), and `tile_done` fires next cycle.
- **Push.** On the 18th bit, the entry `{tile_cnt, row_cnt, row_last, completed row}` is pushed. The completed row includes the bit arriving that cycle, not just the register contents.
- **FIFO.** First-word fall-through. Head fields drive `row_*` and `tile_idx` directly.
- **Handshake.**
  - Pop when `row_valid && row_ready`.
  - `row_data`, `row_idx`, `row_last` and `tile_idx` hold stable while `row_valid && !row_ready`.
  - `row_ready` with an empty FIFO has no effect.
- **Full FIFO.**
  - Push and pop in the same cycle while full: both happen. Count is unchanged and nothing is lost.
  - Push while full with no pop: the new row is dropped and `overflow` is set until `reset`.
  - Counters advance on a drop exactly as they would without it, so later rows keep correct indices.
- **Empty FIFO.** Push and pop cannot coincide, because there is no head to pop.
- **`edge_valid` low.** No state change, except FIFO pops. Gaps of any length mid-row or mid-tile are legal.
- **Reset.**
  - Clears `col_cnt`, `row_cnt`, `tile_cnt`, `shreg`, the FIFO, `overflow` and `tile_done`.
  - Mid-row or mid-tile data is discarded.
  - Reset wins over a simultaneous push or pop.
- **Output reset values.** `row_valid=0`, `row_data=0`, `row_idx=0`, `row_last=0`, `tile_idx=0`, `tile_done=0`, `overflow=0`.

## Timing
- **Row latency.** The 18th bit is sampled at edge N. `row_valid` is high in cycle N+1, i.e. after edge N, when the FIFO was empty.
- **Throughput.** One bit per cycle in. Sustained output is one row per 18 cycles.
- **Overflow margin.** With `row_ready` held low, `FIFO_DEPTH` rows are absorbed. The loss occurs on row `FIFO_DEPTH+1`, which is the 90th bit for the default depth of 4.
- **`tile_done` alignment.** It coincides with the cycle in which the tile's last row first becomes the FIFO-written entry. That row is visible on the head only if the FIFO was empty.

## Structure
- Shared package `edge_pkg`:
  - constants `TILE_EDGE=18`, `TILE_BITS=324`;
  - the row-entry struct type `{tile, row, last, data}`.
- One sub-module, `sync_fifo_fwft`, parameterised by width and depth. It exposes `full`, `empty`, `push`, `pop`.
- Top level contains the counters, shift register, drop logic and sticky flag.

## Test plan
1. **Single tile, sink always ready.** Feed 324 bits; row r is the pattern `18'h2AAAA ^ r`.
   - 18 rows out, `row_idx` 0..17.
   - `row_last` only on row 17.
   - `tile_idx=0`.
   - One `tile_done` pulse, one cycle after bit 324.
2. **Gapped input.** `edge_valid` toggles 1/0; 36 bits.
   - Rows identical to the gapless run.
   - `row_valid` first rises one cycle after bit 18 is sampled.
3. **Backpressure and overflow.** `row_ready=0` throughout 5 rows.
   - 4 rows held, head stable with `row_idx=0`.
   - `overflow` rises the cycle after bit 90.
   - After releasing ready: rows 0..3 out, and the next arriving row reports `row_idx=5`.
4. **Full with simultaneous push/pop.** Fill 4 rows, then assert `row_ready` on exactly the cycle the 5th row completes.
   - `overflow` stays 0.
   - Five rows out, in order.
5. **Tile wrap.** Run 2049 tiles of all-ones.
   - `tile_idx` sequence 2047 → 0 on tile 2049.
   - `row_data=18'h3FFFF`.
6. **Mid-tile reset.** Reset after 100 bits.
   - All outputs return to reset values.
   - The next 18 bits yield `row_idx=0`, `tile_idx=0`.
